// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array feeders:
//   - feed_state_e : feeder FSM encoding (IDLE / FEED / FLUSH)
//   - DEFAULT_WIDTH: default operand width per lane (matches the PE width)
//   - clog2_f      : ceiling log2 usable in parameter/port width expressions
// ----------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2
  } feed_state_e;

  localparam int DEFAULT_WIDTH = 16;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2_f(input int value);
    int result;
    int span;
    result = 32'sd0;
    span   = 32'sd1;
    for (int i = 0; i < 31; i++) begin
      if (span < value) begin
        span   = span * 32'sd2;
        result = result + 32'sd1;
      end else begin
        span   = span;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// ----------------------------------------------------------------------------
// skew_delay_line
// DEPTH-stage shift register, every stage resets to zero. One instance per
// feeder lane produces that lane's diagonal skew.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset
//   d_i   in   [WIDTH-1:0] value entering stage 0 this cycle
//   q_o   out  [WIDTH-1:0] last stage (d_i delayed by DEPTH cycles)
// ----------------------------------------------------------------------------
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift register: advances every cycle, never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// ----------------------------------------------------------------------------
// systolic_skew_feeder
// Edge feeder for a ROWS x COLS processing-element array. Accepts one
// ROWS-wide operand vector per beat and delays lane r by r extra cycles so
// matching a/b operands meet inside the array. Lanes carry zero whenever no
// beat is accepted. After the last beat of a tile the array is flushed for
// ROWS+COLS-1 cycles and tile_done pulses in the first idle cycle.
//
// Optional feature macro: SKEW_FEEDER_PERF_EN adds the bubble_cnt port
// (FEED cycles without s_valid, saturating, cleared after tile_done).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   s_valid    in   input beat valid
//   s_ready    out  feeder accepts a beat (low during FLUSH)
//   s_data     in   [ROWS*WIDTH-1:0] lane r = s_data[r*WIDTH +: WIDTH]
//   s_last     in   final beat of the tile
//   out_data   out  [ROWS*WIDTH-1:0] skewed lanes towards the array edge
//   busy       out  feeder not idle
//   tile_done  out  one-cycle pulse at flush end
//   tile_len   out  beats in the last completed tile
//   k_overflow out  sticky: MAX_K beats seen without s_last
//   bubble_cnt out  [15:0] (SKEW_FEEDER_PERF_EN only) stall cycles in FEED
// ----------------------------------------------------------------------------
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int MAX_K = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [ROWS*WIDTH-1:0]         s_data,
  input  logic                          s_last,
  output logic [ROWS*WIDTH-1:0]         out_data,
  output logic                          busy,
  output logic                          tile_done,
  output logic [clog2_f(MAX_K+1)-1:0]   tile_len,
  output logic                          k_overflow
`ifdef SKEW_FEEDER_PERF_EN
  ,
  output logic [15:0]                   bubble_cnt
`endif
);

  localparam int KW        = clog2_f(MAX_K + 1);
  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FW        = clog2_f(FLUSH_LEN + 1);

  feed_state_e   state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [KW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          ready_q;
  logic          busy_q;
  logic          accept_s;
  logic          hit_max_s;

  assign accept_s  = s_valid && ready_q;
  // The MAX_K-th beat without s_last closes the tile as if s_last were set.
  assign hit_max_s = accept_s && !s_last && (k_q == KW'(MAX_K - 1));

  // Next-state logic: tile sequencing, beat count and flush timing.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    flush_d = flush_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_FEED: begin
        if (accept_s) begin
          k_d = k_q + KW'(1'b1);
          if (s_last || hit_max_s) begin
            state_d = ST_FLUSH;
            flush_d = '0;
          end else begin
            state_d = ST_FEED;
          end
          if (hit_max_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_FLUSH: begin
        if (flush_q == FW'(FLUSH_LEN - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          len_d   = k_q;
          k_d     = '0;
        end else begin
          flush_d = flush_q + FW'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      flush_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      flush_q <= flush_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      // Outputs are derived from the next state so they line up with state_q.
      ready_q <= (state_d != ST_FLUSH);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign s_ready    = ready_q;
  assign busy       = busy_q;
  assign tile_done  = done_q;
  assign tile_len   = len_q;
  assign k_overflow = ovf_q;

`ifdef SKEW_FEEDER_PERF_EN
  logic [15:0] bubble_q, bubble_d;

  // Stall counter: held through tile_done so it can be sampled, then cleared.
  always_comb begin
    bubble_d = bubble_q;
    if (done_q) begin
      bubble_d = 16'h0000;
    end else if ((state_q == ST_FEED) && !s_valid && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'h0001;
    end else begin
      bubble_d = bubble_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_q <= 16'h0000;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;
`endif

  // Lane r gets r+1 stages; cycles without an accepted beat inject zero.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [WIDTH-1:0] lane_in_s;
    assign lane_in_s = accept_s ? s_data[r*WIDTH +: WIDTH] : '0;
    skew_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (r + 1)
    ) u_line (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (lane_in_s),
      .q_o   (out_data[r*WIDTH +: WIDTH])
    );
  end

endmodule
